// File: rtl/two_dig_timer_ctrl_pkg.sv
// Shared encodings for the two-digit run/pause/clear timer controller.
package two_dig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [1:0] SEL_ONES = 2'b01;
    localparam logic [1:0] SEL_TENS = 2'b10;

endpackage

// File: rtl/two_dig_timer_ctrl_if.sv
// Control inputs and display/status outputs of the two-digit timer controller.
interface two_dig_timer_ctrl_if;
    import two_dig_pkg::*;

    // Handshake: start_stop and clear are single-cycle request pulses that are always
    // accepted (no ready). tick is the valid strobe for a new count and wrap qualifies it;
    // the consumer has no ready and must take the value in that cycle.
    logic       start_stop;
    logic       clear;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [1:0] digit_sel;
    logic [3:0] digit_bcd;
    logic       running;
    logic       tick;
    logic       wrap;
    state_t     state;

    modport master (
        output start_stop, clear,
        input  ones, tens, digit_sel, digit_bcd, running, tick, wrap, state
    );

    modport slave (
        input  start_stop, clear,
        output ones, tens, digit_sel, digit_bcd, running, tick, wrap, state
    );

endinterface

// File: rtl/two_dig_timer_ctrl_en_div.sv
// Enable-gated prescaler: counts 0..DIV-1 and pulses combinationally on the wrapping cycle.
module en_div #(
    parameter int DIV = 10,
    parameter int W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic pulse
);

    logic [W-1:0] cnt;

    // clr dominates so a cleared period never emits a stale pulse
    assign pulse = en && !clr && (cnt == W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= pulse ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/two_dig_timer_ctrl.sv
// Run/pause/clear sequencer for a 00-99 BCD counter with two-digit display multiplexing.
module two_dig_timer_ctrl
    import two_dig_pkg::*;
#(
    parameter int DIV_TICK = 10,
    parameter int DIV_SCAN = 4,
    parameter int CNT_W    = 4
) (
    input logic                 clk,
    input logic                 rst,
    two_dig_timer_ctrl_if.slave bus
);

    state_t     state_q, state_d;
    logic       tick_en, tick_clr, tick_pulse, scan_pulse;
    logic [3:0] ones_q, tens_q, ones_d, tens_d;
    logic [3:0] bcd_q, bcd_d;
    logic [1:0] sel_q, sel_d;
    logic       running_q, tick_q, wrap_q, wrap_d;

    assign tick_en  = (state_q == RUN);
    assign tick_clr = (state_q == IDLE) || bus.clear;

    en_div #(.DIV(DIV_TICK), .W(CNT_W)) u_tick_div (
        .clk   (clk),
        .rst   (rst),
        .en    (tick_en),
        .clr   (tick_clr),
        .pulse (tick_pulse)
    );

    en_div #(.DIV(DIV_SCAN), .W(CNT_W)) u_scan_div (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .clr   (1'b0),
        .pulse (scan_pulse)
    );

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else if (bus.start_stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = 1'b0;
        if (bus.clear) begin
            ones_d = '0;
            tens_d = '0;
        end else if (tick_pulse) begin
            if (ones_q == BCD_MAX) begin
                ones_d = '0;
                tens_d = (tens_q == BCD_MAX) ? 4'd0 : tens_q + 4'd1;
                wrap_d = (tens_q == BCD_MAX);
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // digit_bcd is built from next-state values so it never lags digit_sel
    always_comb begin
        sel_d = scan_pulse ? {sel_q[0], sel_q[1]} : sel_q;
        bcd_d = (sel_d == SEL_TENS) ? tens_d : ones_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ones_q    <= '0;
            tens_q    <= '0;
            sel_q     <= SEL_ONES;
            bcd_q     <= '0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            sel_q     <= sel_d;
            bcd_q     <= bcd_d;
            running_q <= (state_d == RUN);
            tick_q    <= tick_pulse;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.ones      = ones_q;
    assign bus.tens      = tens_q;
    assign bus.digit_sel = sel_q;
    assign bus.digit_bcd = bcd_q;
    assign bus.running   = running_q;
    assign bus.tick      = tick_q;
    assign bus.wrap      = wrap_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_two_dig_timer_ctrl.sv
// Directed bench for two_dig_timer_ctrl: tick scoreboard plus timing, scan and reset checks.
module tb_two_dig_timer_ctrl;
    import two_dig_pkg::*;

    localparam int DIV_TICK = 10;
    localparam int DIV_SCAN = 4;

    logic clk = 1'b0;
    logic rst;

    two_dig_timer_ctrl_if bus();

    two_dig_timer_ctrl #(
        .DIV_TICK (DIV_TICK),
        .DIV_SCAN (DIV_SCAN),
        .CNT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // expected {wrap, tens, ones} for every tick the DUT should emit
    logic [8:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int m_ones = 0;
    int m_tens = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_tick();
        logic w;
        w = (m_ones == 9) && (m_tens == 9);
        if (m_ones == 9) begin
            m_ones = 0;
            m_tens = (m_tens == 9) ? 0 : m_tens + 1;
        end else begin
            m_ones = m_ones + 1;
        end
        exp_q.push_back({w, m_tens[3:0], m_ones[3:0]});
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tick && n < limit);
    endtask

    task automatic next_tick(input string name, input int exp_interval);
        int n;
        push_tick();
        wait_tick(2 * DIV_TICK + 5, n);
        chk(name, n, exp_interval);
    endtask

    task automatic pulse_ss();
        bus.start_stop = 1'b1;
        @(negedge clk);
        bus.start_stop = 1'b0;
    endtask

    task automatic scan_check(input string name, input int exp_o, input int exp_t);
        logic [1:0] prev;
        int run;
        int changes;
        prev    = bus.digit_sel;
        run     = 0;
        changes = 0;
        repeat (6 * DIV_SCAN) begin
            @(negedge clk);
            chk({name, "_onehot"}, (bus.digit_sel == SEL_ONES) || (bus.digit_sel == SEL_TENS), 1);
            chk({name, "_bcd"}, bus.digit_bcd, (bus.digit_sel == SEL_TENS) ? exp_t : exp_o);
            if (bus.digit_sel != prev) begin
                if (changes > 0) chk({name, "_period"}, run, DIV_SCAN);
                changes++;
                run  = 1;
                prev = bus.digit_sel;
            end else begin
                run++;
            end
        end
        chk({name, "_changes"}, changes >= 5, 1);
    endtask

    // monitor: every tick the DUT presents is popped against the scoreboard
    always @(negedge clk) begin
        if (!rst && bus.tick) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_tick: got tens=%0d ones=%0d wrap=%0d expected no tick",
                         bus.tens, bus.ones, bus.wrap);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({bus.wrap, bus.tens, bus.ones} !== e) begin
                    errors++;
                    $display("FAIL sb_tick_value: got wrap=%0d tens=%0d ones=%0d expected wrap=%0d tens=%0d ones=%0d",
                             bus.wrap, bus.tens, bus.ones, e[8], e[7:4], e[3:0]);
                end
            end
        end
        if (!rst && bus.wrap && !bus.tick) begin
            checks++;
            errors++;
            $display("FAIL sb_wrap_without_tick: got wrap=1 tick=0 expected wrap=0");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset values
        chk("rst_ones", bus.ones, 0);
        chk("rst_tens", bus.tens, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_tick", bus.tick, 0);
        chk("rst_wrap", bus.wrap, 0);
        chk("rst_digit_sel", bus.digit_sel, 2'b01);
        chk("rst_digit_bcd", bus.digit_bcd, 0);
        chk("rst_state", bus.state, IDLE);

        // start, first tick after DIV_TICK edges, one-cycle tick
        pulse_ss();
        chk("t1_running", bus.running, 1);
        chk("t1_state", bus.state, RUN);
        next_tick("t1_first_interval", DIV_TICK);
        chk("t1_tens", bus.tens, 0);
        @(negedge clk);
        chk("t1_tick_width", bus.tick, 0);

        // count to 99, then wrap to 00
        for (int i = 0; i < 98; i++) next_tick("t2_interval", (i == 0) ? DIV_TICK - 1 : DIV_TICK);
        chk("t2_tens99", bus.tens, 9);
        chk("t2_ones99", bus.ones, 9);
        next_tick("t2_wrap_interval", DIV_TICK);
        chk("t2_wrap", bus.wrap, 1);
        chk("t2_wrap_tick", bus.tick, 1);
        chk("t2_wrap_ones", bus.ones, 0);
        chk("t2_wrap_tens", bus.tens, 0);

        // pause 3 cycles into a period; resume finishes the remaining 7
        repeat (2) @(negedge clk);
        pulse_ss();
        chk("t3_pause_running", bus.running, 0);
        chk("t3_pause_state", bus.state, PAUSE);
        repeat (50) @(negedge clk);
        chk("t3_pause_ones", bus.ones, 0);
        chk("t3_pause_tens", bus.tens, 0);
        pulse_ss();
        chk("t3_resume_running", bus.running, 1);
        next_tick("t3_resume_interval", DIV_TICK - 3);

        // clear beats start_stop at 37
        for (int i = 0; i < 36; i++) next_tick("t4_interval", DIV_TICK);
        chk("t4_at37", {bus.tens, bus.ones}, 8'h37);
        bus.clear      = 1'b1;
        bus.start_stop = 1'b1;
        @(negedge clk);
        bus.clear      = 1'b0;
        bus.start_stop = 1'b0;
        m_ones = 0;
        m_tens = 0;
        chk("t4_clr_running", bus.running, 0);
        chk("t4_clr_state", bus.state, IDLE);
        chk("t4_clr_ones", bus.ones, 0);
        chk("t4_clr_tens", bus.tens, 0);
        repeat (30) @(negedge clk);
        pulse_ss();
        next_tick("t4_restart_interval", DIV_TICK);

        // scan at 42 in PAUSE, then at 00 in IDLE
        for (int i = 0; i < 41; i++) next_tick("t5_interval", DIV_TICK);
        pulse_ss();
        chk("t5_state_pause", bus.state, PAUSE);
        scan_check("t5_pause", 2, 4);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        m_ones = 0;
        m_tens = 0;
        chk("t5_state_idle", bus.state, IDLE);
        scan_check("t5_idle", 0, 0);

        // asynchronous reset between edges at 58
        pulse_ss();
        for (int i = 0; i < 58; i++) next_tick("t6_interval", DIV_TICK);
        repeat (3) @(negedge clk);
        chk("t6_at58", {bus.tens, bus.ones}, 8'h58);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_ones", bus.ones, 0);
        chk("t6_async_tens", bus.tens, 0);
        chk("t6_async_running", bus.running, 0);
        chk("t6_async_tick", bus.tick, 0);
        chk("t6_async_wrap", bus.wrap, 0);
        chk("t6_async_digit_sel", bus.digit_sel, 2'b01);
        chk("t6_async_digit_bcd", bus.digit_bcd, 0);
        chk("t6_async_state", bus.state, IDLE);
        @(negedge clk);
        rst = 1'b0;
        m_ones = 0;
        m_tens = 0;
        repeat (20) @(negedge clk);
        chk("t6_post_state", bus.state, IDLE);
        chk("t6_post_ones", bus.ones, 0);

        chk("sb_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
